// File: rtl/adc_emu_pkg.sv
// -----------------------------------------------------------------------------
// adc_emu_pkg
// Shared definitions for the ADC response emulator: bus widths, the sequencer
// state encoding and the channel-legality helper.
// -----------------------------------------------------------------------------
package adc_emu_pkg;

   localparam int CH_W   = 5;
   localparam int DATA_W = 12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      RESPOND = 2'd2
   } state_e;

   // Channels are numbered 1..num_ch; channel 0 and anything above num_ch
   // are not backed by a table entry.
   function automatic logic ch_valid(input logic [CH_W-1:0] ch, input int num_ch);
      return (ch != '0) && (int'(ch) <= num_ch);
   endfunction

endpackage

// File: rtl/adc_emu_sample_table.sv
// -----------------------------------------------------------------------------
// adc_emu_sample_table
// Per-channel sample register file (NUM_CH entries of DATA_W bits).
//
// Ports:
//   Clk, reset_n   clock, asynchronous active-low reset (entries -> RESET_SAMPLE)
//   wr_en          synchronous write strobe
//   wr_channel     write channel (1..NUM_CH; others ignored)
//   wr_data        write value
//   smp_en         latch strobe: capture the entry of smp_channel into smp_data
//   smp_channel    channel being sampled (illegal channels read as zero)
//   ramp_en        bit k: advance entry k+1 by RAMP_STEP after it is sampled
//   smp_data       value captured on the last smp_en edge
// -----------------------------------------------------------------------------
module adc_emu_sample_table
   import adc_emu_pkg::*;
#(
   parameter int                NUM_CH       = 8,
   parameter int                RAMP_STEP    = 16,
   parameter logic [DATA_W-1:0] RESET_SAMPLE = 12'h800
) (
   input  logic              Clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_channel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              smp_en,
   input  logic [CH_W-1:0]   smp_channel,
   input  logic [NUM_CH-1:0] ramp_en,
   output logic [DATA_W-1:0] smp_data
);

   logic [DATA_W-1:0] mem [NUM_CH];
   logic [DATA_W-1:0] rd_value;
   logic [NUM_CH-1:0] wr_hit;
   logic [NUM_CH-1:0] ramp_hit;

   // Channel decode. Entry k holds channel k+1, so channel 0 and channels
   // above NUM_CH never match and read back as zero.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      rd_value = '0;
      wr_hit   = '0;
      ramp_hit = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (smp_channel == CH_W'(k + 1)) begin
            rd_value = mem[k];
         end
         wr_hit[k]   = wr_en && (wr_channel == CH_W'(k + 1));
         ramp_hit[k] = smp_en && ramp_en[k] && (smp_channel == CH_W'(k + 1));
      end
   end

   // NOTE: the table is a handful of flops, not a RAM macro, and must come out
   // of reset holding RESET_SAMPLE, so every entry is cleared in the reset branch.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            mem[k] <= RESET_SAMPLE;
         end
         smp_data <= '0;
      end else begin
         // NOTE: non-blocking assignments mean the sample below sees the
         // pre-edge entry even when a write or ramp lands on the same edge.
         for (int k = 0; k < NUM_CH; k++) begin
            // A host write overrides the ramp advance of the same entry.
            if (wr_hit[k]) begin
               mem[k] <= wr_data;
            end else if (ramp_hit[k]) begin
               mem[k] <= mem[k] + DATA_W'(RAMP_STEP);
            end
         end
         if (smp_en) begin
            smp_data <= rd_value;
         end
      end
   end

endmodule

// File: rtl/adc_response_emulator.sv
// -----------------------------------------------------------------------------
// adc_response_emulator
// Responder end of the ADC command/response Avalon-ST link. Each accepted
// command returns one response beat CONV_CYCLES edges later carrying the
// current table value for that channel.
//
// Ports:
//   Clk, reset_n                 clock, asynchronous active-low reset
//   command_valid/channel        command request (sop/eop inputs are ignored)
//   command_ready                command taken on valid && ready
//   response_valid               one-cycle beat, no backpressure
//   response_channel/data        channel echo and 12-bit sample (held between beats)
//   response_startofpacket/eop   both equal response_valid
//   wr_en/wr_channel/wr_data     sample table write port
//   ramp_en                      bit k ramps channel k+1 after each of its samples
//   clr_bad                      clears bad_channel (wins over a same-cycle set)
//   bad_channel                  sticky: an illegal channel was accepted
//   sample_count                 number of response beats, wraps at 16 bits
//
// Timing for an accept on edge 0: CONVERT for CONV_CYCLES-1 cycles, the table
// is sampled (and ramped) on edge CONV_CYCLES-1 as the RESPOND state is
// entered, and the beat is registered out on edge CONV_CYCLES. A new command
// may be accepted during RESPOND, giving one beat every CONV_CYCLES cycles.
// -----------------------------------------------------------------------------
module adc_response_emulator
   import adc_emu_pkg::*;
#(
   parameter int                CONV_CYCLES  = 50,
   parameter int                NUM_CH       = 8,
   parameter int                RAMP_STEP    = 16,
   parameter logic [DATA_W-1:0] RESET_SAMPLE = 12'h800
) (
   input  logic              Clk,
   input  logic              reset_n,
   input  logic              command_valid,
   input  logic [CH_W-1:0]   command_channel,
   input  logic              command_startofpacket,
   input  logic              command_endofpacket,
   output logic              command_ready,
   output logic              response_valid,
   output logic [CH_W-1:0]   response_channel,
   output logic [DATA_W-1:0] response_data,
   output logic              response_startofpacket,
   output logic              response_endofpacket,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_channel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [NUM_CH-1:0] ramp_en,
   input  logic              clr_bad,
   output logic              bad_channel,
   output logic [15:0]       sample_count
);

   // Counter only ever holds CONV_CYCLES-1 down to 1.
   localparam int CNT_W = $clog2(CONV_CYCLES);

   state_e            state_q;
   state_e            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CH_W-1:0]   ch_q;
   logic              run_q;
   logic              accept;
   logic              smp_en;
   logic [DATA_W-1:0] smp_data;

   // Packet framing on the command side carries no information here.
   logic unused_sop_eop;
   assign unused_sop_eop = &{1'b0, command_startofpacket, command_endofpacket};

   // ---------------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      command_ready = 1'b0;
      case (state_q)
         IDLE: begin
            command_ready = run_q;
            if (command_valid && run_q) begin
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESPOND;
            end
         end
         RESPOND: begin
            command_ready = run_q;
            state_d       = (command_valid && run_q) ? CONVERT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = command_valid && command_ready;
   // Last CONVERT cycle: the edge ending it enters RESPOND and samples the table.
   assign smp_en = (state_q == CONVERT) && (cnt_q == CNT_W'(1));

   // run_q keeps command_ready low while reset is asserted and for the first
   // cycle after release, even though the state register already reads IDLE.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         ch_q  <= '0;
      end else if (accept) begin
         cnt_q <= CNT_W'(CONV_CYCLES - 1);
         ch_q  <= command_channel;
      end else if (state_q == CONVERT) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Sample table
   // ---------------------------------------------------------------------------
   adc_emu_sample_table #(
      .NUM_CH       (NUM_CH),
      .RAMP_STEP    (RAMP_STEP),
      .RESET_SAMPLE (RESET_SAMPLE)
   ) u_table (
      .Clk         (Clk),
      .reset_n     (reset_n),
      .wr_en       (wr_en),
      .wr_channel  (wr_channel),
      .wr_data     (wr_data),
      .smp_en      (smp_en),
      .smp_channel (ch_q),
      .ramp_en     (ramp_en),
      .smp_data    (smp_data)
   );

   // ---------------------------------------------------------------------------
   // Response beat, flags and beat counter
   // ---------------------------------------------------------------------------
   // The beat is registered as RESPOND is left; channel and data keep their
   // last values between beats. ch_q may be reloaded by a back-to-back accept
   // on this same edge, but the beat takes the value it held during RESPOND.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         response_valid   <= 1'b0;
         response_channel <= '0;
         response_data    <= '0;
         sample_count     <= '0;
         bad_channel      <= 1'b0;
      end else begin
         response_valid <= (state_q == RESPOND);
         if (state_q == RESPOND) begin
            response_channel <= ch_q;
            response_data    <= smp_data;
            sample_count     <= sample_count + 16'd1;
         end
         if (clr_bad) begin
            bad_channel <= 1'b0;
         end else if (accept && !ch_valid(command_channel, NUM_CH)) begin
            bad_channel <= 1'b1;
         end
      end
   end

   assign response_startofpacket = response_valid;
   assign response_endofpacket   = response_valid;

endmodule

// File: tb/tb_adc_response_emulator.sv
// -----------------------------------------------------------------------------
// tb_adc_response_emulator
// Directed scenarios followed by a randomized run. Expected outputs come from a
// transaction-level model: each accepted command is a job stamped with the edge
// on which its sample is taken (accept + CONV - 1) and it becomes a beat one
// edge later; the table is a plain array updated by the ramp and write rules.
// -----------------------------------------------------------------------------
module tb_adc_response_emulator;

   localparam int          CONV  = 4;
   localparam int          NCH   = 8;
   localparam int          STEP  = 16;
   localparam logic [11:0] RST_S = 12'h800;

   logic           Clk = 1'b0;
   logic           reset_n;
   logic           command_valid;
   logic [4:0]     command_channel;
   logic           command_startofpacket;
   logic           command_endofpacket;
   logic           command_ready;
   logic           response_valid;
   logic [4:0]     response_channel;
   logic [11:0]    response_data;
   logic           response_startofpacket;
   logic           response_endofpacket;
   logic           wr_en;
   logic [4:0]     wr_channel;
   logic [11:0]    wr_data;
   logic [NCH-1:0] ramp_en;
   logic           clr_bad;
   logic           bad_channel;
   logic [15:0]    sample_count;

   always #5 Clk = ~Clk;

   adc_response_emulator #(
      .CONV_CYCLES  (CONV),
      .NUM_CH       (NCH),
      .RAMP_STEP    (STEP),
      .RESET_SAMPLE (RST_S)
   ) dut (
      .Clk                    (Clk),
      .reset_n                (reset_n),
      .command_valid          (command_valid),
      .command_channel        (command_channel),
      .command_startofpacket  (command_startofpacket),
      .command_endofpacket    (command_endofpacket),
      .command_ready          (command_ready),
      .response_valid         (response_valid),
      .response_channel       (response_channel),
      .response_data          (response_data),
      .response_startofpacket (response_startofpacket),
      .response_endofpacket   (response_endofpacket),
      .wr_en                  (wr_en),
      .wr_channel             (wr_channel),
      .wr_data                (wr_data),
      .ramp_en                (ramp_en),
      .clr_bad                (clr_bad),
      .bad_channel            (bad_channel),
      .sample_count           (sample_count)
   );

   // ---------------------------------------------------------------- model
   typedef struct {
      logic [4:0]  ch;
      int          smp_edge;
      logic [11:0] data;
   } job_t;

   job_t        jobs[$];
   logic [11:0] m_tab [1:NCH];
   int          edge_n;
   int          free_edge;
   logic        m_valid;
   logic [4:0]  m_ch;
   logic [11:0] m_data;
   logic        m_bad;
   logic [15:0] m_cnt;

   int tests = 0;
   int fails = 0;

   function automatic bit legal(input logic [4:0] c);
      return (c >= 5'd1) && (int'(c) <= NCH);
   endfunction

   task automatic model_reset();
      jobs.delete();
      for (int c = 1; c <= NCH; c++) m_tab[c] = RST_S;
      edge_n    = 0;
      free_edge = 2;   // ready rises one cycle after release
      m_valid   = 1'b0;
      m_ch      = '0;
      m_data    = '0;
      m_bad     = 1'b0;
      m_cnt     = '0;
   endtask

   // Applies the inputs that were stable across the edge just taken.
   task automatic model_edge();
      bit took;
      bit bad_req;
      edge_n++;
      m_valid = 1'b0;
      if (jobs.size() > 0 && jobs[0].smp_edge + 1 == edge_n) begin
         m_valid = 1'b1;
         m_ch    = jobs[0].ch;
         m_data  = jobs[0].data;
         m_cnt   = m_cnt + 16'd1;
         void'(jobs.pop_front());
      end
      for (int i = 0; i < jobs.size(); i++) begin
         if (jobs[i].smp_edge == edge_n) begin
            if (legal(jobs[i].ch)) begin
               jobs[i].data = m_tab[jobs[i].ch];
               if (ramp_en[jobs[i].ch - 1]) m_tab[jobs[i].ch] = m_tab[jobs[i].ch] + 12'(STEP);
            end else begin
               jobs[i].data = 12'h000;
            end
         end
      end
      if (wr_en && legal(wr_channel)) m_tab[wr_channel] = wr_data;
      took    = command_valid && (edge_n >= free_edge);
      bad_req = took && !legal(command_channel);
      if (took) begin
         job_t j;
         j.ch       = command_channel;
         j.smp_edge = edge_n + CONV - 1;
         j.data     = 12'h000;
         jobs.push_back(j);
         free_edge = edge_n + CONV;
      end
      if (clr_bad)      m_bad = 1'b0;
      else if (bad_req) m_bad = 1'b1;
   endtask

   // ---------------------------------------------------------------- checks
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic check_all();
      logic exp_ready;
      exp_ready = reset_n && (edge_n + 1 >= free_edge);
      check("ready",   32'(command_ready),          32'(exp_ready));
      check("valid",   32'(response_valid),         32'(m_valid));
      check("sop",     32'(response_startofpacket), 32'(m_valid));
      check("eop",     32'(response_endofpacket),   32'(m_valid));
      check("channel", 32'(response_channel),       32'(m_ch));
      check("data",    32'(response_data),          32'(m_data));
      check("bad",     32'(bad_channel),            32'(m_bad));
      check("count",   32'(sample_count),           32'(m_cnt));
   endtask

   task automatic cyc();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      check_all();
   endtask

   task automatic idle_inputs();
      command_valid         = 1'b0;
      command_channel       = '0;
      command_startofpacket = 1'b0;
      command_endofpacket   = 1'b0;
      wr_en                 = 1'b0;
      wr_channel            = '0;
      wr_data               = '0;
      clr_bad               = 1'b0;
   endtask

   task automatic send(input logic [4:0] ch, input int n);
      command_valid         = 1'b1;
      command_channel       = ch;
      command_startofpacket = 1'b1;
      command_endofpacket   = 1'b1;
      repeat (n) cyc();
      command_valid         = 1'b0;
      command_startofpacket = 1'b0;
      command_endofpacket   = 1'b0;
   endtask

   task automatic write(input logic [4:0] ch, input logic [11:0] d);
      wr_en      = 1'b1;
      wr_channel = ch;
      wr_data    = d;
      cyc();
      wr_en      = 1'b0;
   endtask

   task automatic held_reset(input int n);
      repeat (n) begin
         @(posedge Clk);
         @(negedge Clk);
         check_all();
      end
   endtask

   // Absolute time bound in case the run is stuck somewhere unexpected.
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "time limit");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      idle_inputs();
      ramp_en = '0;
      reset_n = 1'b0;
      model_reset();
      @(negedge Clk);
      held_reset(3);
      reset_n = 1'b1;

      // 1: continuous commands on channel 3
      check_all();
      send(5'd3, 14);
      repeat (6) cyc();

      // 2: write channel 5, single command on it
      write(5'd5, 12'h123);
      send(5'd5, 1);
      repeat (8) cyc();

      // 3: ramp across the 12-bit wrap on channel 2
      write(5'd2, 12'hFF0);
      ramp_en = 8'b0000_0010;
      send(5'd2, 9);
      repeat (6) cyc();

      // 4: illegal channels, clear, and clear racing a new set
      send(5'd0, 1);
      repeat (5) cyc();
      send(5'd9, 1);
      repeat (5) cyc();
      clr_bad = 1'b1;
      cyc();
      clr_bad = 1'b0;
      cyc();
      clr_bad = 1'b1;
      send(5'd0, 1);
      clr_bad = 1'b0;
      repeat (5) cyc();

      // 5: write landing on the sample edge of a ramping channel
      ramp_en = 8'b0000_1010;
      send(5'd4, 1);
      for (int i = 0; i < 2 * CONV && jobs.size() > 0 && edge_n + 1 < jobs[$].smp_edge; i++) cyc();
      write(5'd4, 12'hABC);
      repeat (5) cyc();
      send(5'd4, 1);
      repeat (6) cyc();

      // 6: reset in the middle of a conversion
      send(5'd5, 1);
      cyc();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge Clk);
      held_reset(2);
      reset_n = 1'b1;
      repeat (8) cyc();
      send(5'd5, 1);
      repeat (6) cyc();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         command_valid         = ($urandom_range(0, 9) < 7);
         command_channel       = 5'($urandom_range(0, 10));
         command_startofpacket = command_valid;
         command_endofpacket   = command_valid;
         wr_en                 = ($urandom_range(0, 4) == 0);
         wr_channel            = 5'($urandom_range(0, 10));
         wr_data               = 12'($urandom);
         clr_bad               = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 31) == 0) ramp_en = NCH'($urandom);
         cyc();
      end
      idle_inputs();
      repeat (2 * CONV) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adc_response_emulator.md
Name: adc_response_emulator

Overview:
- Synthesizable stand-in for the modular ADC sequencer: the responder end of the ADC command/response Avalon-ST interface.
- Accepts the same command stream the game top level issues (valid, channel, sop/eop) and returns timed response beats (valid, channel, 12-bit data, sop/eop).
- Per-channel sample values come from a writable table with optional auto-ramp, so the lock-picking game and acceleration path run in simulation and on boards without the analog front end.

Parameters:
- CONV_CYCLES, 50: clock edges from command accept to response beat; legal range ≥2.
- NUM_CH, 8: valid channels 1..NUM_CH; channel 0 and channels >NUM_CH are invalid.
- RAMP_STEP, 16: increment applied to a ramping channel after each of its responses.
- RESET_SAMPLE, 12'h800: table value after reset.

Ports:
- Clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- command_valid  in  1  command request.
- command_channel  in  5  requested channel.
- command_startofpacket  in  1  ignored.
- command_endofpacket  in  1  ignored.
- command_ready  out  1  command accepted when valid&&ready.
- response_valid  out  1  one-cycle response beat; no backpressure.
- response_channel  out  5  channel of the accepted command.
- response_data  out  12  sample value.
- response_startofpacket  out  1  equals response_valid.
- response_endofpacket  out  1  equals response_valid.
- wr_en  in  1  table write strobe.
- wr_channel  in  5  table write channel.
- wr_data  in  12  table write value.
- ramp_en  in  NUM_CH  bit k enables ramp for channel k+1.
- clr_bad  in  1  clears bad_channel.
- bad_channel  out  1  sticky flag: an invalid channel was accepted.
- sample_count  out  16  count of response beats; wraps at 16'hFFFF→0.

Behaviour:
Reset (async, reset_n=0):
- State IDLE; command_ready=0 while reset_n is low.
- response_valid=0; response_channel=0; response_data=0; bad_channel=0; sample_count=0.
- All table entries = RESET_SAMPLE.
- Any pending conversion is dropped; no response is emitted for it.

FSM:
- IDLE: command_ready=1. On valid&&ready, latch channel, load counter=CONV_CYCLES-1, go to CONVERT.
- CONVERT: command_ready=0; counter decrements each cycle. When counter==1, go to RESPOND.
- RESPOND (one cycle): response_valid=1, response_channel=latched channel, response_data=table value sampled on the entry edge, sample_count increments. command_ready=1.
  - If a command is accepted in RESPOND, go to CONVERT (back-to-back); otherwise go to IDLE.

Timing:
- Command accepted at edge 0 → response_valid high during the cycle following edge CONV_CYCLES.
- With continuous command_valid, sustained throughput is one beat per CONV_CYCLES cycles.
- response_channel and response_data hold their last values when response_valid=0.

Data rules:
- Invalid channel: response still emitted after the same latency, with response_data=12'h000 and the channel echoed. bad_channel sets on the accept edge.
- clr_bad has priority over a same-cycle set.
- Ramp: on the RESPOND-entry edge, if ramp_en[ch-1]=1, entry ← (entry+RAMP_STEP) mod 4096. The wrap is silent; 12'hFF0+16 → 12'h000.
- Write: wr_en writes table[wr_channel] when wr_channel is valid; invalid write channels are ignored.
- Write and sample latch on the same edge and same channel: the response carries the old value, and the table takes wr_data. The write wins over the ramp update.
- Table contents are not cleared by idle periods; they are cleared only by reset.

Decomposition:
- Package adc_emu_pkg:
  - CH_W=5, DATA_W=12.
  - State enum {IDLE, CONVERT, RESPOND}.
  - Function ch_valid(ch, NUM_CH).
- Sub-module adc_emu_sample_table: NUM_CH×12 register file with a synchronous write port, a read-at-latch port, ramp update, and the write-over-ramp priority.
- The top holds the FSM, counter, flags and sample_count.

Test Plan (CONV_CYCLES=4, NUM_CH=8, RAMP_STEP=16):
1. Release reset, hold valid=1 with ch=3 → ready=1 one cycle after release. response_valid pulses every 4 cycles with ch=3, data=12'h800, sop=eop=1. sample_count increments each beat.
2. Write ch 5=12'h123, then send one command on ch 5 → single beat 4 edges after accept, data=12'h123. ready=0 for the 3 CONVERT cycles. No further beats.
3. Write ch 2=12'hFF0, set ramp_en[1]=1, send 3 commands on ch 2 → data 12'hFF0, 12'h000, 12'h010.
4. Command on ch 0, then on ch 9 → both beats data=12'h000, channels 0 and 9 echoed, bad_channel=1. Pulse clr_bad → 0. Assert clr_bad in the same cycle as a new bad accept → bad_channel stays 0.
5. Write ch 4=12'hABC on the RESPOND-entry edge of a ch 4 conversion with ramp on → beat shows the old value; the next beat shows 12'hABC, not 12'hABC+16.
6. Drop reset_n mid-CONVERT → outputs cleared immediately, table back to 12'h800, no beat after release until a new accept.
